// File: rtl/decoder_stage_controller.sv
// Sequencer for the decoder PU array: load -> grow/merge rounds -> peel -> result.
// Optional DECODE_CYCLE_COUNTER_EN adds a saturating decode-length counter on cycle_count.
module decoder_stage_controller #(
  parameter int PU_COUNT       = 60,
  parameter int MAX_ITERATIONS = 16,
  parameter int SETTLE_CYCLES  = 3,
  parameter int ITER_WIDTH     = 5,
  localparam int STAGE_WIDTH   = 3
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   measurements_valid,
  output logic                   measurements_ready,
  input  logic [PU_COUNT-1:0]    measurements_in,
  output logic [PU_COUNT-1:0]    measurement_out,
  output logic [STAGE_WIDTH-1:0] global_stage,
  input  logic [PU_COUNT-1:0]    busy_in,
  input  logic [PU_COUNT-1:0]    odd_in,
  output logic                   result_valid,
  input  logic                   result_ready,
  output logic [ITER_WIDTH-1:0]  iteration_count,
  output logic                   overflow,
  output logic [31:0]            cycle_count
);

  // state    | meaning
  // IDLE     | waiting for a syndrome round, ready high
  // LOAD     | PUs absorbing measurement_out (2 cycles)
  // GROW     | one cluster-grow cycle, bumps iteration_count
  // MERGE    | settle, then wait for busy clear and decide on odd
  // PEEL     | settle, then wait for busy clear
  // RESULT   | result_valid held until result_ready

  localparam logic [STAGE_WIDTH-1:0] STAGE_IDLE               = 3'd0;
  localparam logic [STAGE_WIDTH-1:0] STAGE_MEASUREMENT_LOADING = 3'd1;
  localparam logic [STAGE_WIDTH-1:0] STAGE_GROW               = 3'd2;
  localparam logic [STAGE_WIDTH-1:0] STAGE_MERGE              = 3'd3;
  localparam logic [STAGE_WIDTH-1:0] STAGE_PEELING            = 3'd4;
  localparam logic [STAGE_WIDTH-1:0] STAGE_RESULT_VALID       = 3'd5;

  localparam int TIMER_W = (SETTLE_CYCLES > 2) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [TIMER_W-1:0] LOAD_TIMER   = TIMER_W'(1);
  localparam logic [TIMER_W-1:0] SETTLE_TIMER = TIMER_W'(SETTLE_CYCLES - 1);
  localparam logic [ITER_WIDTH-1:0] ITER_MAX  = ITER_WIDTH'(MAX_ITERATIONS);

  typedef enum logic [STAGE_WIDTH-1:0] {
    S_IDLE   = STAGE_IDLE,
    S_LOAD   = STAGE_MEASUREMENT_LOADING,
    S_GROW   = STAGE_GROW,
    S_MERGE  = STAGE_MERGE,
    S_PEEL   = STAGE_PEELING,
    S_RESULT = STAGE_RESULT_VALID
  } state_t;

  state_t             state, state_next;
  logic [TIMER_W-1:0] timer, timer_next;
  logic               accept;
  logic               set_overflow;
  logic               wait_done;

  assign accept             = (state == S_IDLE) && measurements_valid;
  assign measurements_ready = (state == S_IDLE);
  assign result_valid       = (state == S_RESULT);
  assign global_stage       = state;
  // busy/odd only matter once the shared down-counter has expired
  assign wait_done          = (timer == '0) && ~|busy_in;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next   = state;
    set_overflow = 1'b0;
    case (state)
      S_IDLE:   if (measurements_valid) state_next = S_LOAD;
      S_LOAD:   if (timer == '0) state_next = S_GROW;
      S_GROW:   state_next = S_MERGE;
      S_MERGE: begin
        if (wait_done) begin
          if (~|odd_in) begin
            state_next = S_PEEL;
          end else if (iteration_count == ITER_MAX) begin
            state_next   = S_RESULT;
            set_overflow = 1'b1;
          end else begin
            state_next = S_GROW;
          end
        end
      end
      S_PEEL:   if (wait_done) state_next = S_RESULT;
      S_RESULT: if (result_ready) state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  // One down-counter times both the LOAD dwell and the MERGE/PEEL settle window.
  always_comb begin
    timer_next = timer;
    if (state_next != state && state_next == S_LOAD)
      timer_next = LOAD_TIMER;
    else if (state_next != state && (state_next == S_MERGE || state_next == S_PEEL))
      timer_next = SETTLE_TIMER;
    else if (timer != '0)
      timer_next = timer - TIMER_W'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      timer           <= '0;
      measurement_out <= '0;
      iteration_count <= '0;
      overflow        <= 1'b0;
    end else begin
      timer <= timer_next;
      if (accept) begin
        measurement_out <= measurements_in;
        iteration_count <= '0;
        overflow        <= 1'b0;
      end else begin
        if (state == S_GROW && iteration_count != ITER_MAX)
          iteration_count <= iteration_count + ITER_WIDTH'(1);
        if (set_overflow)
          overflow <= 1'b1;
      end
    end
  end

`ifdef DECODE_CYCLE_COUNTER_EN
  logic [31:0] cycle_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cycle_q <= '0;
    end else if (accept) begin
      cycle_q <= '0;
    end else if ((state == S_LOAD || state == S_GROW || state == S_MERGE || state == S_PEEL)
                 && cycle_q != 32'hFFFF_FFFF) begin
      cycle_q <= cycle_q + 32'd1;
    end
  end

  assign cycle_count = cycle_q;
`else
  assign cycle_count = 32'd0;
`endif

endmodule

// File: tb/tb_decoder_stage_controller.sv
// Directed bench for decoder_stage_controller: vector table of full decodes plus
// hand-written busy-stall and mid-decode reset sequences.
module tb_decoder_stage_controller;
  localparam int PU   = 60;
  localparam int MAXI = 4;
  localparam int IW   = 5;
`ifdef DECODE_CYCLE_COUNTER_EN
  localparam bit CC_EN = 1'b1;
`else
  localparam bit CC_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          measurements_valid;
  logic          measurements_ready;
  logic [PU-1:0] measurements_in;
  logic [PU-1:0] measurement_out;
  logic [2:0]    global_stage;
  logic [PU-1:0] busy_in;
  logic [PU-1:0] odd_in;
  logic          result_valid;
  logic          result_ready;
  logic [IW-1:0] iteration_count;
  logic          overflow;
  logic [31:0]   cycle_count;

  decoder_stage_controller #(
    .PU_COUNT(PU), .MAX_ITERATIONS(MAXI), .SETTLE_CYCLES(3), .ITER_WIDTH(IW)
  ) dut (
    .clk(clk), .reset(reset),
    .measurements_valid(measurements_valid), .measurements_ready(measurements_ready),
    .measurements_in(measurements_in), .measurement_out(measurement_out),
    .global_stage(global_stage), .busy_in(busy_in), .odd_in(odd_in),
    .result_valid(result_valid), .result_ready(result_ready),
    .iteration_count(iteration_count), .overflow(overflow), .cycle_count(cycle_count)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [PU-1:0] pattern;
    int            n_odd;
    int            hold;
    int            exp_iter;
    logic          exp_ovf;
    int            exp_merge;
    int            exp_peel;
    int            exp_cycles;
  } vec_t;

  vec_t vecs[4];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] cexp(input int v);
    return CC_EN ? 32'(v) : 32'd0;
  endfunction

  task automatic accept_round(input logic [PU-1:0] pat);
    measurements_in    = pat;
    measurements_valid = 1'b1;
    step();
    measurements_valid = 1'b0;
  endtask

  task automatic consume(input string tag);
    result_ready = 1'b1;
    step();
    result_ready = 1'b0;
    chk({tag, "_idle_after_ready"}, {60'd0, global_stage, result_valid}, {60'd0, 3'd0, 1'b0});
    chk({tag, "_ready_in_idle"}, 64'(measurements_ready), 64'd1);
  endtask

  task automatic run_vec(input int i);
    int nl, ng, nm, np;
    bit done;
    logic [PU-1:0] one;
    string t;
    t = $sformatf("v%0d", i);
    one = 1;
    nl = 0; ng = 0; nm = 0; np = 0; done = 0;
    busy_in = '0;
    odd_in  = '0;
    accept_round(vecs[i].pattern);
    chk({t, "_ready_low"}, 64'(measurements_ready), 64'd0);
    chk({t, "_meas_latched"}, 64'(measurement_out), 64'(vecs[i].pattern));
    for (int c = 0; c < 300 && !done; c++) begin
      case (global_stage)
        3'd1: nl++;
        3'd2: ng++;
        3'd3: nm++;
        3'd4: np++;
        3'd5: done = 1;
        default: ;
      endcase
      odd_in = (ng > 0 && ng <= vecs[i].n_odd) ? (one << ((ng * 7) % PU)) : '0;
      if (!done) step();
    end
    odd_in = '0;
    chk({t, "_reached_result"}, 64'(done), 64'd1);
    chk({t, "_load_cycles"}, 64'(nl), 64'd2);
    chk({t, "_grow_cycles"}, 64'(ng), 64'(vecs[i].exp_iter));
    chk({t, "_merge_cycles"}, 64'(nm), 64'(vecs[i].exp_merge));
    chk({t, "_peel_cycles"}, 64'(np), 64'(vecs[i].exp_peel));
    chk({t, "_iteration_count"}, 64'(iteration_count), 64'(vecs[i].exp_iter));
    chk({t, "_overflow"}, 64'(overflow), 64'(vecs[i].exp_ovf));
    chk({t, "_cycle_count"}, 64'(cycle_count), 64'(cexp(vecs[i].exp_cycles)));
    for (int h = 0; h < vecs[i].hold; h++) begin
      step();
      chk({t, "_result_hold_stage"}, {61'd0, global_stage}, 64'd5);
      chk({t, "_result_hold_outputs"},
          {result_valid, measurements_ready, overflow, iteration_count, cycle_count},
          {1'b1, 1'b0, vecs[i].exp_ovf, IW'(vecs[i].exp_iter), cexp(vecs[i].exp_cycles)});
    end
    consume(t);
    step();
    chk({t, "_cycle_count_frozen_idle"}, 64'(cycle_count), 64'(cexp(vecs[i].exp_cycles)));
  endtask

  initial begin
    int nm;
    bit ok;
    logic [PU-1:0] pat;

    vecs[0] = '{pattern: '0,                       n_odd: 0,  hold: 0, exp_iter: 1, exp_ovf: 1'b0, exp_merge: 3,  exp_peel: 3, exp_cycles: 9};
    vecs[1] = '{pattern: 60'hABC_DEF0_1234_5678,   n_odd: 2,  hold: 5, exp_iter: 3, exp_ovf: 1'b0, exp_merge: 9,  exp_peel: 3, exp_cycles: 17};
    vecs[2] = '{pattern: 60'hFFF_FFFF_FFFF_FFFF,   n_odd: 99, hold: 2, exp_iter: 4, exp_ovf: 1'b1, exp_merge: 12, exp_peel: 0, exp_cycles: 18};
    vecs[3] = '{pattern: 60'h800_0000_0000_0001,   n_odd: 1,  hold: 1, exp_iter: 2, exp_ovf: 1'b0, exp_merge: 6,  exp_peel: 3, exp_cycles: 13};

    reset = 1'b0;
    measurements_valid = 1'b0;
    measurements_in = '0;
    busy_in = '0;
    odd_in = '0;
    result_ready = 1'b0;
    #12;
    chk("reset_stage", 64'(global_stage), 64'd0);
    chk("reset_outputs", {measurement_out, result_valid, overflow, iteration_count},
        {60'd0, 1'b0, 1'b0, 5'd0});
    chk("reset_cycle_count", 64'(cycle_count), 64'd0);
    reset = 1'b1;
    step();
    chk("ready_after_reset", 64'(measurements_ready), 64'd1);

    for (int i = 0; i < 4; i++) run_vec(i);

    // busy bit 5 held through the first 10 MERGE cycles, with ignored valid pulses
    pat = 60'h123_4567_89AB_CDEF;
    accept_round(pat);
    ok = 0;
    for (int c = 0; c < 20 && !ok; c++) begin
      if (global_stage == 3'd3) ok = 1;
      else step();
    end
    chk("busy_reached_merge", 64'(ok), 64'd1);
    nm = 0;
    busy_in[5] = 1'b1;
    for (int k = 0; k < 10; k++) begin
      if (global_stage == 3'd3) nm++;
      measurements_valid = (k % 2 == 0);
      measurements_in = ~pat;
      step();
    end
    busy_in = '0;
    measurements_valid = 1'b0;
    for (int c = 0; c < 20 && global_stage == 3'd3; c++) begin
      nm++;
      step();
    end
    chk("busy_merge_cycles", 64'(nm), 64'd11);
    chk("busy_then_peel", 64'(global_stage), 64'd4);
    chk("busy_meas_unchanged", 64'(measurement_out), 64'(pat));
    for (int c = 0; c < 20 && global_stage != 3'd5; c++) step();
    chk("busy_result", 64'(result_valid), 64'd1);
    chk("busy_cycle_count", 64'(cycle_count), 64'(cexp(2 + 1 + 11 + 3)));
    consume("busy");

    // asynchronous reset in the middle of iteration-2 MERGE
    accept_round(60'h0F0_F0F0_F0F0_F0F0);
    odd_in = 60'h1;
    ok = 0;
    for (int c = 0; c < 40 && !ok; c++) begin
      if (global_stage == 3'd3 && iteration_count == 5'd2) ok = 1;
      else step();
    end
    chk("rst_reached_merge_iter2", 64'(ok), 64'd1);
    step();
    #2 reset = 1'b0;
    #1;
    chk("rst_async_stage", 64'(global_stage), 64'd0);
    chk("rst_async_iter", 64'(iteration_count), 64'd0);
    chk("rst_async_other", {measurement_out, result_valid, overflow, cycle_count},
        {60'd0, 1'b0, 1'b0, 32'd0});
    odd_in = '0;
    @(posedge clk);
    #3 reset = 1'b1;
    #1;
    chk("rst_ready_after_release", 64'(measurements_ready), 64'd1);
    step();
    chk("rst_stays_idle", 64'(global_stage), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end
endmodule

// File: doc/decoder_stage_controller.md
DECODER_STAGE_CONTROLLER -- requirements
Module: decoder_stage_controller

Interface
REQ-001 Parameter PU_COUNT, default 60, number of processing units driven (one measurement bit and one busy/odd bit each).
REQ-002 Parameter MAX_ITERATIONS, default 16, grow/merge rounds allowed before overflow.
REQ-003 Parameter SETTLE_CYCLES, default 3, minimum cycles spent in MERGE or PEELING before busy is sampled (covers PU stage register plus busy register).
REQ-004 Parameter ITER_WIDTH, default 5, width of iteration counter; SHALL satisfy 2^ITER_WIDTH > MAX_ITERATIONS.
REQ-005 clk  input  1  sole clock; all state updates on rising edge.
REQ-006 reset  input  1  asynchronous, active-low reset.
REQ-007 measurements_valid  input  1  upstream offers a syndrome round.
REQ-008 measurements_ready  output  1  controller accepts a round this cycle.
REQ-009 measurements_in  input  PU_COUNT  syndrome bits, one per PU.
REQ-010 measurement_out  output  PU_COUNT  registered syndrome bits driven to PU measurement inputs.
REQ-011 global_stage  output  STAGE_WIDTH  stage broadcast to all PUs, encoded with the shared STAGE_* constants.
REQ-012 busy_in  input  PU_COUNT  per-PU busy flags.
REQ-013 odd_in  input  PU_COUNT  per-PU odd flags.
REQ-014 result_valid  output  1  decode finished; held until result_ready.
REQ-015 result_ready  input  1  downstream consumes result.
REQ-016 iteration_count  output  ITER_WIDTH  grow rounds performed in current/last decode.
REQ-017 overflow  output  1  decode ended because MAX_ITERATIONS was reached with odd clusters remaining.
REQ-018 cycle_count  output  32  total cycles from accept to result_valid (see Configuration).

Function
REQ-019 States: IDLE, LOAD, GROW, MERGE, PEEL, RESULT; global_stage = STAGE_IDLE, STAGE_MEASUREMENT_LOADING, STAGE_GROW, STAGE_MERGE, STAGE_PEELING, STAGE_RESULT_VALID respectively, registered.
REQ-020 IDLE: measurements_ready=1; on measurements_valid the controller latches measurements_in into measurement_out, clears iteration_count and overflow, enters LOAD.
REQ-021 measurements_ready SHALL be 0 in every state except IDLE; measurement_out SHALL hold unchanged from latch until the next accept.
REQ-022 LOAD lasts exactly 2 cycles, then GROW.
REQ-023 GROW lasts exactly 1 cycle, increments iteration_count (saturating at MAX_ITERATIONS), then MERGE.
REQ-024 MERGE: a settle counter counts SETTLE_CYCLES cycles from entry; after that, the first cycle with busy_in all-zero is the decision cycle.
REQ-025 Decision: odd_in all-zero -> PEEL; else iteration_count == MAX_ITERATIONS -> set overflow, RESULT; else -> GROW.
REQ-026 PEEL: same settle rule; first subsequent cycle with busy_in all-zero -> RESULT.
REQ-027 RESULT: result_valid=1; on result_ready=1 in the same cycle -> IDLE next cycle; result_valid drops with the transition.
REQ-028 busy_in/odd_in SHALL be ignored outside MERGE/PEEL after settle; toggling busy during settle SHALL not advance state.
REQ-029 measurements_valid asserted while not in IDLE SHALL be ignored (not latched, not queued).
REQ-030 Settle counter resets on every entry to MERGE or PEEL.

Reset
REQ-031 Assertion of reset, at any time including mid-decode, forces IDLE asynchronously: global_stage=STAGE_IDLE, measurement_out=0, measurements_ready=1 after release, result_valid=0, iteration_count=0, overflow=0, cycle_count=0, settle counter=0.
REQ-032 First state change after release requires a rising clk edge with reset high.

Configuration
REQ-033 Macro DECODE_CYCLE_COUNTER_EN: when defined, cycle_count clears on accept, increments every cycle in LOAD/GROW/MERGE/PEEL, freezes in RESULT and IDLE, saturates at 2^32-1.
REQ-034 When undefined, cycle_count SHALL be constant 0 and no counter register synthesized; all other behaviour identical.

Verification
REQ-035 Reset mid-MERGE (iteration 2): assert reset -> same cycle global_stage=STAGE_IDLE, iteration_count=0; after release measurements_ready=1.
REQ-036 All-zero syndrome, busy/odd held 0 -> LOAD 2, GROW 1, MERGE 3 cycles, PEEL 3 cycles, result_valid; iteration_count=1, overflow=0, cycle_count=9 (macro on).
REQ-037 odd_in nonzero for 2 merge decisions then 0 -> iteration_count=3, one PEEL phase, overflow=0.
REQ-038 odd_in stuck 1, MAX_ITERATIONS=4 -> result_valid with iteration_count=4, overflow=1, no PEEL state visited.
REQ-039 busy_in bit 5 held 1 for 10 cycles in MERGE -> controller stays MERGE until cycle after busy clears; measurements_valid pulses meanwhile ignored, measurement_out unchanged.
REQ-040 result_ready held 0 for 5 cycles -> result_valid, global_stage=STAGE_RESULT_VALID, all outputs stable; with macro undefined cycle_count=0 throughout.
